// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage multi-cycle divider: FSM encodings,
// level constants and the operand magnitude helper.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        DivStart  = 1'b1;
  localparam logic        DivStop   = 1'b0;
  localparam logic        RstEnable = 1'b0;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider handshake: operands, start/annul levels, result and stall.
interface div_unit_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration on the 65-bit {partial remainder, quotient}
// work register: shift left, trial-subtract the divisor, keep or restore.
module div_step (
  input  logic [64:0] work,
  input  logic [31:0] divisor,
  output logic [64:0] work_nxt,
  output logic        q_bit
);
  logic [64:0] shifted;
  logic [32:0] diff;

  assign shifted  = work << 1;
  assign diff     = shifted[64:32] - {1'b0, divisor};
  assign q_bit    = ~diff[32];
  assign work_nxt = q_bit ? {diff, shifted[31:0] | 32'd1} : shifted;
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider for MIPS div/divu; returns {rem, quo}.
// Optional DIV_EARLY_TERM_EN: skip iterations when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  dif
);
  div_state_e  state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [64:0] work, work_n, step_nxt;
  logic [31:0] divisor, divisor_n;
  logic        sgn, sgn_n, neg1, neg1_n, neg2, neg2_n;
  logic [63:0] result_q, result_n;
  logic        ready_q, ready_n;
  logic        q_bit;
  logic [31:0] abs1, abs2, quo_fix, rem_fix;

  assign abs1 = mag32(dif.signed_div_i, dif.opdata1_i);
  assign abs2 = mag32(dif.signed_div_i, dif.opdata2_i);

  div_step u_step (
    .work     (work),
    .divisor  (divisor),
    .work_nxt (step_nxt),
    .q_bit    (q_bit)
  );

  // Remainder takes the dividend's sign; quotient negates on sign mismatch.
  assign quo_fix = (sgn && (neg1 ^ neg2)) ? (~work[31:0] + 32'd1) : work[31:0];
  assign rem_fix = (sgn && neg1) ? (~work[63:32] + 32'd1) : work[63:32];

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    work_n    = work;
    divisor_n = divisor;
    sgn_n     = sgn;
    neg1_n    = neg1;
    neg2_n    = neg2;
    ready_n   = 1'b0;
    result_n  = {ZeroWord, ZeroWord};
    if (dif.annul_i) begin
      state_n = DIV_FREE;
    end else begin
      case (state)
        DIV_FREE: begin
          if (dif.start_i == DivStart) begin
            if (dif.opdata2_i == ZeroWord) begin
              state_n = DIV_BY_ZERO;
            end else begin
              sgn_n     = dif.signed_div_i;
              neg1_n    = dif.signed_div_i & dif.opdata1_i[31];
              neg2_n    = dif.signed_div_i & dif.opdata2_i[31];
              divisor_n = abs2;
              cnt_n     = 5'd0;
              work_n    = {33'd0, abs1};
              state_n   = DIV_ON;
`ifdef DIV_EARLY_TERM_EN
              // Quotient is 0 and the whole dividend is the remainder.
              if (abs1 < abs2) begin
                work_n  = {1'b0, abs1, ZeroWord};
                state_n = DIV_END;
              end
`endif
            end
          end
        end
        DIV_BY_ZERO: begin
          work_n  = 65'd0;
          sgn_n   = 1'b0;
          neg1_n  = 1'b0;
          neg2_n  = 1'b0;
          state_n = DIV_END;
        end
        DIV_ON: begin
          work_n = step_nxt;
          cnt_n  = cnt + 5'd1;
          if (cnt == 5'd31) state_n = DIV_END;
        end
        DIV_END: begin
          if (dif.start_i == DivStop) begin
            state_n = DIV_FREE;
          end else begin
            ready_n  = 1'b1;
            result_n = {rem_fix, quo_fix};
          end
        end
        default: state_n = DIV_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state    <= DIV_FREE;
      cnt      <= 5'd0;
      work     <= 65'd0;
      divisor  <= ZeroWord;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_q <= {ZeroWord, ZeroWord};
      ready_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      work     <= work_n;
      divisor  <= divisor_n;
      sgn      <= sgn_n;
      neg1     <= neg1_n;
      neg2     <= neg2_n;
      result_q <= result_n;
      ready_q  <= ready_n;
    end
  end

  assign dif.result_o = result_q;
  assign dif.ready_o  = ready_q;
  assign dif.stall_o  = dif.start_i & ~ready_q & ~dif.annul_i;
endmodule
